// File: rtl/fpnew_result_reorder_if.sv
// Result-reorder port bundle: allocation, completion and in-order retire channels.
// The small status package lives here so the interface can carry the flag type.
package fpnew_pkg;
    typedef struct packed {
        logic nv; // invalid
        logic dz; // divide by zero
        logic of; // overflow
        logic uf; // underflow
        logic nx; // inexact
    } status_t;
endpackage

interface fpnew_result_reorder_if #(
    parameter int unsigned Width   = 32,
    parameter int unsigned Depth   = 4,
    parameter type         TagType = logic
);
    localparam int unsigned IdWidth = $clog2(Depth);

    logic                 flush_i;
    logic                 alloc_valid_i;
    TagType               alloc_tag_i;
    logic                 alloc_ready_o;
    logic [IdWidth-1:0]   alloc_id_o;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [IdWidth-1:0]   in_id_i;
    logic [Width-1:0]     in_result_i;
    fpnew_pkg::status_t   in_status_i;
    logic                 in_ext_bit_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [Width-1:0]     result_o;
    fpnew_pkg::status_t   status_o;
    logic                 extension_bit_o;
    TagType               tag_o;
    logic                 busy_o;

    modport master (
        output flush_i, alloc_valid_i, alloc_tag_i,
        input  alloc_ready_o, alloc_id_o,
        output in_valid_i, in_id_i, in_result_i, in_status_i, in_ext_bit_i,
        input  in_ready_o,
        input  out_valid_o, result_o, status_o, extension_bit_o, tag_o, busy_o,
        output out_ready_i
    );

    modport slave (
        input  flush_i, alloc_valid_i, alloc_tag_i,
        output alloc_ready_o, alloc_id_o,
        input  in_valid_i, in_id_i, in_result_i, in_status_i, in_ext_bit_i,
        output in_ready_o,
        output out_valid_o, result_o, status_o, extension_bit_o, tag_o, busy_o,
        input  out_ready_i
    );
endinterface

// File: rtl/fpnew_result_reorder.sv
// Reorder buffer: accepts out-of-order opgroup results keyed by slot ID and
// releases them in allocation order.
module fpnew_result_reorder #(
    parameter int unsigned Width   = 32,
    parameter int unsigned Depth   = 4,
    parameter type         TagType = logic
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    fpnew_result_reorder_if.slave  bus
);
    localparam int unsigned IdWidth = $clog2(Depth);
    localparam int unsigned CntW    = IdWidth + 1;

    logic [IdWidth-1:0] head_q, head_d;
    logic [IdWidth-1:0] tail_q, tail_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [Depth-1:0]   alloc_q, alloc_d;
    logic [Depth-1:0]   done_q, done_d;
    logic [Width-1:0]   result_q [Depth];
    logic [Width-1:0]   result_d [Depth];
    fpnew_pkg::status_t status_q [Depth];
    fpnew_pkg::status_t status_d [Depth];
    logic [Depth-1:0]   ext_q, ext_d;
    TagType             tag_q [Depth];
    TagType             tag_d [Depth];

    logic alloc_fire, in_fire, ret_fire;

    assign bus.alloc_ready_o   = (count_q < CntW'(Depth));
    assign bus.alloc_id_o      = tail_q;
    assign bus.in_ready_o      = !bus.flush_i;
    assign bus.busy_o          = (count_q != '0);
    assign bus.out_valid_o     = done_q[head_q];
    assign bus.result_o        = result_q[head_q];
    assign bus.status_o        = status_q[head_q];
    assign bus.extension_bit_o = ext_q[head_q];
    assign bus.tag_o           = tag_q[head_q];

    // Next-state: retire at head, complete by ID, allocate at tail; flush overrides all.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        alloc_d  = alloc_q;
        done_d   = done_q;
        result_d = result_q;
        status_d = status_q;
        ext_d    = ext_q;
        tag_d    = tag_q;

        // alloc_ready_o comes from the registered count, so a same-cycle retire
        // never makes room for an allocation.
        alloc_fire = bus.alloc_valid_i && bus.alloc_ready_o && !bus.flush_i;
        // Writes to unallocated or already-completed slots are dropped.
        in_fire    = bus.in_valid_i && bus.in_ready_o
                     && alloc_q[bus.in_id_i] && !done_q[bus.in_id_i];
        ret_fire   = bus.out_valid_o && bus.out_ready_i && !bus.flush_i;

        if (ret_fire) begin
            alloc_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + IdWidth'(1);
        end

        if (in_fire) begin
            done_d[bus.in_id_i]   = 1'b1;
            result_d[bus.in_id_i] = bus.in_result_i;
            status_d[bus.in_id_i] = bus.in_status_i;
            ext_d[bus.in_id_i]    = bus.in_ext_bit_i;
        end

        if (alloc_fire) begin
            alloc_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            tag_d[tail_q]   = bus.alloc_tag_i;
            tail_d          = tail_q + IdWidth'(1);
        end

        count_d = count_q + CntW'(alloc_fire) - CntW'(ret_fire);

        if (bus.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            alloc_d = '0;
            done_d  = '0;
        end
    end

    // State registers; reset clears pointers, flags and storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            alloc_q  <= '0;
            done_q   <= '0;
            result_q <= '{default: '0};
            status_q <= '{default: '0};
            ext_q    <= '0;
            tag_q    <= '{default: '0};
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            alloc_q  <= alloc_d;
            done_q   <= done_d;
            result_q <= result_d;
            status_q <= status_d;
            ext_q    <= ext_d;
            tag_q    <= tag_d;
        end
    end

    a_legal_completion: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (bus.in_valid_i && bus.in_ready_o) |-> (alloc_q[bus.in_id_i] && !done_q[bus.in_id_i])
    );

endmodule

// File: doc/fpnew_result_reorder.md
# fpnew_result_reorder

Reorder buffer on the result side of an FPU opgroup. Issue logic allocates a slot ID per operation and carries that ID as the operation tag. Format slices and merged slices complete at different latencies, so results return out of order. The block accepts those out-of-order results, keyed by ID, and releases them in allocation (program) order through a valid/ready output port.

## Interface
Parameters:
- Width, 32, result width in bits.
- Depth, 4, number of in-flight slots; power of two, ≥2.
- TagType, logic, user tag stored at allocation and returned with the result.
- IdWidth (localparam), $clog2(Depth), slot ID width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  synchronous flush of all slots.
- alloc_valid_i  in  1  request to allocate a slot.
- alloc_tag_i  in  TagType  user tag for the new slot.
- alloc_ready_o  out  1  a slot is free.
- alloc_id_o  out  IdWidth  ID granted on an alloc handshake (tail pointer).
- in_valid_i  in  1  completed result from the opgroup.
- in_ready_o  out  1  always 1 (a slot is pre-reserved); low only during flush_i.
- in_id_i  in  IdWidth  slot ID carried as the operation tag.
- in_result_i  in  Width  result value.
- in_status_i  in  fpnew_pkg::status_t  exception flags.
- in_ext_bit_i  in  1  extension bit.
- out_valid_o  out  1  head slot is complete.
- out_ready_i  in  1  consumer accepts.
- result_o  out  Width  head result.
- status_o  out  fpnew_pkg::status_t  head flags.
- extension_bit_o  out  1  head extension bit.
- tag_o  out  TagType  head user tag.
- busy_o  out  1  at least one slot is allocated.

## Operation
- State:
  - head and tail pointers, IdWidth bits each, wrapping modulo Depth.
  - count, 0..Depth, IdWidth+1 bits.
  - Per slot: alloc bit, done bit, result, status, ext_bit, tag.
- Allocation: alloc_ready_o = (count < Depth).
  - Alloc handshake: write the tag to slot[tail]; set alloc[tail]; clear done[tail]; tail++.
  - A retire in the same cycle does not free a slot for allocation (no bypass). When full, an alloc plus retire in one cycle allocates nothing.
- Completion: in_valid_i && in_ready_o writes result/status/ext_bit into slot[in_id_i] and sets done[in_id_i].
  - Writing a slot whose alloc bit is clear, or whose done bit is already set, is illegal. A simulation assertion flags it; the write is ignored.
- Retire: out_valid_o = done[head]; outputs are driven combinationally from slot[head].
  - On out_valid_o && out_ready_i: clear alloc[head] and done[head]; head++; count--.
- Count update: count += alloc_fire − retire_fire. Simultaneous alloc and retire leaves count unchanged.
- busy_o = (count != 0).
- Flush: head, tail and count go to 0, all alloc/done bits clear, and an in_valid_i or alloc in that cycle is dropped.
  - Outputs in the flush cycle still reflect pre-flush state.
  - out_valid_o is 0 from the next cycle.
- Reset (asynchronous, rst_ni low): all state 0, including storage.
  - Output reset values: alloc_ready_o=1, alloc_id_o=0, in_ready_o=1, out_valid_o=0, result_o=0, status_o=0, extension_bit_o=0, tag_o=0, busy_o=0.
  - Reset asserted mid-operation discards all slots immediately.

## Timing
- Completion → out_valid_o latency: 1 cycle minimum, from the in handshake edge to out_valid_o high when the slot is at head. No same-cycle write-through.
- Back-to-back retire: one result per cycle while consecutive head slots are done and out_ready_i is high.
- alloc_ready_o, alloc_id_o and busy_o depend only on registered state. out_valid_o and the data outputs are a mux from registered state.
- The outputs hold stable while out_valid_o && !out_ready_i.
- The alloc, in and out handshakes are independent and may all fire in the same cycle.

## Test plan
- Reset, then 4 allocs with tags A..D: alloc_id_o = 0,1,2,3; alloc_ready_o drops after the 4th; busy_o=1.
- Complete IDs in order 2, 0, 3, 1 with results 0x40000000, 0x3F800000, 0x40400000, 0x40800000:
  - out_valid_o rises 1 cycle after ID0 is written, outputting 0x3F800000/tag A.
  - Nothing further is output until ID1 is written.
  - Then 1, 2, 3 are output on consecutive cycles with tags B, C, D.
- Full buffer, head done, alloc_valid_i and out_ready_i both high: retire occurs, no allocation, count=3; next cycle alloc grants ID 0 (wrap).
- Stall: head done with out_ready_i=0 for 5 cycles → result_o/status_o/tag_o stable and out_valid_o held; then out_ready_i=1 → retires once.
- Flush with 3 slots allocated (1 done) and in_valid_i high in the same cycle → next cycle count=0, out_valid_o=0, busy_o=0, alloc_id_o=0.
- Assert rst_ni low while 2 slots are done and out_ready_i=0 → all outputs take their reset values asynchronously; after release, the first alloc gets ID 0.
